crc_host: RTL and testbench

CRC_HOST -- requirements
Module: crc_host

---
 rtl/crc_host_if.sv | 21 ++
 rtl/crc_host.sv | 153 +++++++++++++++
 tb/tb_crc_host.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_host_if.sv
// rtl/crc_host_if.sv - register bus and data-word stream between crc_host and its peers
interface crc_host_if;
    logic        Sel;
    logic        RW;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;

    modport master (
        output Sel, RW, addr, data_wr, s_ready,
        input  data_rd, s_valid, s_data
    );

    modport slave (
        input  Sel, RW, addr, data_wr, s_ready,
        output data_rd, s_valid, s_data
    );
endinterface

// File: rtl/crc_host.sv
// rtl/crc_host.sv - sequences a CRC job: program GPOLY/CTRL/seed, stream data words, read back result
module crc_host #(
    parameter logic [31:0] CRC_BASE = 32'h4003_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_gpoly,
    input  logic [31:0] cfg_ctrl,
    input  logic [31:0] cfg_seed,
    input  logic [7:0]  cfg_len,
    crc_host_if.master  bus,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [31:0] ADDR_DATA  = CRC_BASE;
    localparam logic [31:0] ADDR_GPOLY = CRC_BASE + 32'd4;
    localparam logic [31:0] ADDR_CTRL  = CRC_BASE + 32'd8;
    localparam logic [31:0] WAS_MASK   = 32'h0200_0000;

    typedef enum logic [3:0] {
        IDLE,
        W_POLY,
        W_CTRL_S,
        W_SEED,
        W_CTRL_D,
        WAIT_D,
        W_DATA,
        R_RES,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] gpoly_q;
    logic [31:0] ctrl_q;
    logic [31:0] seed_q;
    logic [7:0]  cnt;

    assign bus.s_ready = (state == WAIT_D);

    // Bus outputs are registered: each transition loads the values for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gpoly_q     <= '0;
            ctrl_q      <= '0;
            seed_q      <= '0;
            cnt         <= '0;
            bus.Sel     <= 1'b0;
            bus.RW      <= 1'b0;
            bus.addr    <= '0;
            bus.data_wr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            bus.Sel     <= 1'b0;
            bus.RW      <= 1'b0;
            bus.addr    <= '0;
            bus.data_wr <= '0;
            done        <= 1'b0;

            if (state != IDLE && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            gpoly_q     <= cfg_gpoly;
                            ctrl_q      <= cfg_ctrl & ~WAS_MASK;
                            seed_q      <= cfg_seed;
                            cnt         <= cfg_len;
                            busy        <= 1'b1;
                            state       <= W_POLY;
                            bus.Sel     <= 1'b1;
                            bus.RW      <= 1'b1;
                            bus.addr    <= ADDR_GPOLY;
                            bus.data_wr <= cfg_gpoly;
                        end
                    end
                    W_POLY: begin
                        state       <= W_CTRL_S;
                        bus.Sel     <= 1'b1;
                        bus.RW      <= 1'b1;
                        bus.addr    <= ADDR_CTRL;
                        bus.data_wr <= ctrl_q | WAS_MASK;
                    end
                    W_CTRL_S: begin
                        state       <= W_SEED;
                        bus.Sel     <= 1'b1;
                        bus.RW      <= 1'b1;
                        bus.addr    <= ADDR_DATA;
                        bus.data_wr <= seed_q;
                    end
                    W_SEED: begin
                        state       <= W_CTRL_D;
                        bus.Sel     <= 1'b1;
                        bus.RW      <= 1'b1;
                        bus.addr    <= ADDR_CTRL;
                        bus.data_wr <= ctrl_q;
                    end
                    W_CTRL_D: begin
                        if (cnt != 8'd0) begin
                            state <= WAIT_D;
                        end else begin
                            state    <= R_RES;
                            bus.Sel  <= 1'b1;
                            bus.addr <= ADDR_DATA;
                        end
                    end
                    WAIT_D: begin
                        if (bus.s_valid) begin
                            state       <= W_DATA;
                            bus.Sel     <= 1'b1;
                            bus.RW      <= 1'b1;
                            bus.addr    <= ADDR_DATA;
                            bus.data_wr <= bus.s_data;
                        end
                    end
                    W_DATA: begin
                        cnt <= cnt - 8'd1;
                        // cnt still holds the pre-decrement value here, so 1 means this was the last word.
                        if (cnt != 8'd1) begin
                            state <= WAIT_D;
                        end else begin
                            state    <= R_RES;
                            bus.Sel  <= 1'b1;
                            bus.addr <= ADDR_DATA;
                        end
                    end
                    R_RES: begin
                        result <= bus.data_rd;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_host.sv
// tb/tb_crc_host.sv - randomized self-checking bench for crc_host against a transaction-list model
module tb_crc_host;

    localparam logic [31:0] BASE = 32'h4003_2000;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] cfg_gpoly;
    logic [31:0] cfg_ctrl;
    logic [31:0] cfg_seed;
    logic [7:0]  cfg_len;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] rsp_val;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] w_word  [256];
    int          w_stall [256];

    always #5 clk = ~clk;

    crc_host_if bus ();

    assign bus.data_rd = (bus.Sel && !bus.RW) ? rsp_val : 32'h0;

    crc_host #(.CRC_BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_gpoly (cfg_gpoly),
        .cfg_ctrl  (cfg_ctrl),
        .cfg_seed  (cfg_seed),
        .cfg_len   (cfg_len),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // Expected job: four config writes, the data words in order, one read; done at 6+2N+stalls.
    task automatic run_job(input string name, input logic [31:0] g, input logic [31:0] c,
                           input logic [31:0] sd, input int len, input logic [31:0] rsp,
                           input int second_start_cyc, input int abort_cyc);
        txn_t        exp_q[$];
        txn_t        t;
        int          total_stall = 0;
        int          exp_done;
        int          done_cyc = -1;
        int          done_cnt = 0;
        int          rdy_cnt = 0;
        int          bad_idle = 0;
        int          bad_busy = 0;
        int          sel_after_abort = 0;
        int          widx = 0;
        int          stall_left;
        int          budget;
        logic [31:0] prev_result;

        exp_q.push_back({1'b1, BASE + 32'd4, g});
        exp_q.push_back({1'b1, BASE + 32'd8, c | 32'h0200_0000});
        exp_q.push_back({1'b1, BASE, sd});
        exp_q.push_back({1'b1, BASE + 32'd8, c & ~32'h0200_0000});
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b1, BASE, w_word[i]});
            total_stall += w_stall[i];
        end
        exp_q.push_back({1'b0, BASE, 32'h0});
        exp_done   = 6 + 2 * len + total_stall;
        stall_left = (len != 0) ? w_stall[0] : 0;
        prev_result = result;

        @(negedge clk);
        start     = 1'b1;
        cfg_gpoly = g;
        cfg_ctrl  = c;
        cfg_seed  = sd;
        cfg_len   = len[7:0];
        rsp_val   = rsp;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cfg_gpoly = $urandom;
        cfg_ctrl  = $urandom;
        cfg_seed  = $urandom;
        cfg_len   = 8'($urandom);

        budget = (abort_cyc > 0) ? abort_cyc + 12 : exp_done + 10;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            if (bus.Sel === 1'b1) begin
                n_cmp++;
                if (abort_cyc > 0 && cyc > abort_cyc) sel_after_abort++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL %s extra_txn cyc=%0d got rw=%b addr=%h data=%h expected none",
                             name, cyc, bus.RW, bus.addr, bus.data_wr);
                end else begin
                    t = exp_q.pop_front();
                    if (bus.RW !== t.rw || bus.addr !== t.addr || (t.rw && bus.data_wr !== t.data)) begin
                        n_mis++;
                        $display("FAIL %s txn cyc=%0d got rw=%b addr=%h data=%h expected rw=%b addr=%h data=%h",
                                 name, cyc, bus.RW, bus.addr, bus.data_wr, t.rw, t.addr, t.data);
                    end
                end
            end else if (bus.RW !== 1'b0 || bus.addr !== 32'h0 || bus.data_wr !== 32'h0) begin
                bad_idle++;
            end
            if (bus.s_ready === 1'b1) rdy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (abort_cyc == 0 && done_cyc < 0 && busy !== 1'b1) begin
                bad_busy++;
            end

            if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
                n_cmp++;
                if (bus.Sel !== 1'b0 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
                    n_mis++;
                    $display("FAIL %s after_abort got Sel=%b busy=%b s_ready=%b expected 0 0 0",
                             name, bus.Sel, busy, bus.s_ready);
                end
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_mis++;
                    $display("FAIL %s post_done got busy=%b done=%b expected 0 0", name, busy, done);
                end
                break;
            end

            if (cyc == abort_cyc) abort = 1'b1;
            if (cyc == second_start_cyc) begin
                start     = 1'b1;
                cfg_gpoly = $urandom;
                cfg_ctrl  = $urandom;
                cfg_seed  = $urandom;
                cfg_len   = 8'($urandom);
            end

            if (bus.s_ready === 1'b1 && widx < len) begin
                if (stall_left > 0) begin
                    bus.s_valid = 1'b0;
                    stall_left--;
                end else begin
                    bus.s_valid = 1'b1;
                    bus.s_data  = w_word[widx];
                    widx++;
                    stall_left = (widx < len) ? w_stall[widx] : 0;
                end
            end else begin
                bus.s_valid = 1'($urandom_range(0, 1));
                bus.s_data  = $urandom;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        bus.s_valid = 1'b0;

        n_cmp++;
        if (bad_idle != 0) begin
            n_mis++;
            $display("FAIL %s idle_bus got %0d dirty idle cycles expected 0", name, bad_idle);
        end
        if (abort_cyc == 0) begin
            n_cmp++;
            if (done_cyc != exp_done) begin
                n_mis++;
                $display("FAIL %s done_cycle got %0d expected %0d", name, done_cyc, exp_done);
            end
            n_cmp++;
            if (done_cnt != 1) begin
                n_mis++;
                $display("FAIL %s done_pulses got %0d expected 1", name, done_cnt);
            end
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_mis++;
                $display("FAIL %s missing_txn got %0d left expected 0", name, exp_q.size());
            end
            n_cmp++;
            if (result !== rsp) begin
                n_mis++;
                $display("FAIL %s result got %h expected %h", name, result, rsp);
            end
            n_cmp++;
            if (rdy_cnt != len + total_stall) begin
                n_mis++;
                $display("FAIL %s s_ready_cycles got %0d expected %0d", name, rdy_cnt, len + total_stall);
            end
            n_cmp++;
            if (bad_busy != 0) begin
                n_mis++;
                $display("FAIL %s busy_during_job got %0d low cycles expected 0", name, bad_busy);
            end
        end else begin
            n_cmp++;
            if (done_cnt != 0 || sel_after_abort != 0) begin
                n_mis++;
                $display("FAIL %s abort_quiet got done=%0d sel=%0d expected 0 0", name, done_cnt, sel_after_abort);
            end
            n_cmp++;
            if (result !== prev_result) begin
                n_mis++;
                $display("FAIL %s abort_result got %h expected %h", name, result, prev_result);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.Sel, bus.RW, bus.addr, bus.data_wr, bus.s_ready, busy, done, result} !== '0) begin
            n_mis++;
            $display("FAIL reset_async got Sel=%b RW=%b addr=%h data_wr=%h s_ready=%b busy=%b done=%b result=%h expected all 0",
                     bus.Sel, bus.RW, bus.addr, bus.data_wr, bus.s_ready, busy, done, result);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.Sel, busy, done, result} !== '0) begin
            n_mis++;
            $display("FAIL reset_held got Sel=%b busy=%b done=%b result=%h expected 0", bus.Sel, busy, done, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        w_word[0] = 32'h1111_1111; w_stall[0] = 0;
        w_word[1] = 32'h2222_2222; w_stall[1] = 0;
        run_job("basic", 32'h04C1_1DB7, 32'h0100_0000, 32'hFFFF_FFFF, 2, 32'h89AB_CDEF, 0, 0);
    endtask

    task automatic test_zero_len();
        run_job("zero_len", $urandom, 32'h0000_0000, $urandom, 0, $urandom, 0, 0);
    endtask

    task automatic test_stall();
        w_word[0] = $urandom; w_stall[0] = 3;
        w_word[1] = $urandom; w_stall[1] = 0;
        run_job("stall", $urandom, $urandom, $urandom, 2, $urandom, 0, 0);
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < 3; i++) begin
            w_word[i] = $urandom; w_stall[i] = 0;
        end
        run_job("start_busy", $urandom, $urandom, $urandom, 3, $urandom, 3, 0);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 4; i++) begin
            w_word[i] = $urandom; w_stall[i] = 0;
        end
        run_job("abort", $urandom, $urandom, $urandom, 4, $urandom, 0, 6);
    endtask

    task automatic test_idle_abort_priority();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) begin
            n_cmp++;
            if (busy !== 1'b0 || bus.Sel !== 1'b0) begin
                n_mis++;
                $display("FAIL idle_abort got busy=%b Sel=%b expected 0 0", busy, bus.Sel);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int len;
        for (int j = 0; j < 6; j++) begin
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) begin
                w_word[i]  = $urandom;
                w_stall[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            end
            run_job("random", $urandom, $urandom, $urandom, len, $urandom, 0, 0);
        end
    endtask

    task automatic test_len_255();
        for (int i = 0; i < 255; i++) begin
            w_word[i] = $urandom; w_stall[i] = 0;
        end
        run_job("len255", $urandom, $urandom, $urandom, 255, $urandom, 0, 0);
    endtask

    task automatic test_reset_midjob();
        @(negedge clk);
        start     = 1'b1;
        cfg_gpoly = $urandom;
        cfg_ctrl  = $urandom;
        cfg_seed  = $urandom;
        cfg_len   = 8'd3;
        @(posedge clk);
        #1;
        start       = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = $urandom;
        for (int cyc = 1; cyc <= 6; cyc++) @(negedge clk);
        n_cmp++;
        if (bus.Sel !== 1'b1 || bus.RW !== 1'b1 || bus.addr !== BASE) begin
            n_mis++;
            $display("FAIL midjob_wdata got Sel=%b RW=%b addr=%h expected 1 1 %h", bus.Sel, bus.RW, bus.addr, BASE);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.Sel, bus.RW, bus.addr, bus.data_wr, bus.s_ready, busy, done, result} !== '0) begin
            n_mis++;
            $display("FAIL midjob_reset got Sel=%b RW=%b addr=%h data_wr=%h s_ready=%b busy=%b done=%b result=%h expected all 0",
                     bus.Sel, bus.RW, bus.addr, bus.data_wr, bus.s_ready, busy, done, result);
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        w_word[0] = $urandom; w_stall[0] = 1;
        w_word[1] = $urandom; w_stall[1] = 0;
        run_job("after_reset", $urandom, $urandom, $urandom, 2, $urandom, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired got no finish expected finish");
        $fatal(1);
    end

    initial begin
        start       = 1'b0;
        abort       = 1'b0;
        cfg_gpoly   = '0;
        cfg_ctrl    = '0;
        cfg_seed    = '0;
        cfg_len     = '0;
        rsp_val     = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_start_while_busy();
        test_abort();
        test_idle_abort_priority();
        test_random();
        test_len_255();
        test_reset_midjob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
